seq_monitor: RTL and testbench
==============================

Name: seq_monitor

Overview:
- Downstream consumer of the 3-bit T-flip-flop counter output.
- Samples the counter value each qualified cycle and checks it against the fixed counter sequence 0 -> 3 -> 5 -> 6 -> 0.
- Declares lock after a run of correct transitions, then flags and counts sequence errors.
- Used as an on-chip health monitor for the counter chain.

Parameters:
- LOCK_COUNT, 4, consecutive correct transitions needed to enter LOCKED (legal range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- q_in  input  3  counter value under test.
- valid  input  1  sample qualifier; q_in is ignored when 0.
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  high while the FSM is in LOCKED.
- phase  output  2  sequence index of the last accepted value (0->0, 3->1, 5->2, 6->3).
- err_pulse  output  1  one-cycle pulse on a mismatch while LOCKED.
- illegal  output  1  one-cycle pulse when a valid q_in is outside {0,3,5,6}.
- err_count  output  ERR_W  saturating count of err_pulse events.

Behaviour:
- Reset:
  - Applied on a clk edge with reset==0.
  - state=HUNT; prev=0; match_cnt=0.
  - Outputs: locked=0, phase=0, err_pulse=0, illegal=0, err_count=0.
  - Reset wins over every other input.
  - Reset mid-operation drops lock immediately and does not count as an error.
- Definitions:
  - Legal set {0,3,5,6}.
  - next(0)=3, next(3)=5, next(5)=6, next(6)=0.
  - match = valid && q_in==next(prev). A repeated value is a mismatch.
- Latency: all outputs are registered. The response to a sample appears the cycle after the edge on which it is sampled.
- With valid==0: state, prev, match_cnt and phase hold; pulses deassert.
- FSM states are HUNT, CHECK and LOCKED.
- HUNT:
  - Valid and legal: prev<=q_in, match_cnt<=0, go to CHECK.
  - Valid and illegal: illegal pulses, stay in HUNT.
- CHECK:
  - match: prev<=q_in and match_cnt++. When match_cnt+1==LOCK_COUNT, go to LOCKED and clear match_cnt.
  - Legal non-match: prev<=q_in, match_cnt<=0, stay in CHECK.
  - Illegal: illegal pulses, go to HUNT.
- LOCKED:
  - match: prev<=q_in, stay in LOCKED.
  - Non-match: err_pulse pulses and err_count increments, then:
    - if q_in is legal: prev<=q_in, match_cnt<=0, go to CHECK;
    - if q_in is illegal: illegal also pulses, go to HUNT.
- locked is high on the cycle after the LOCKED transition and low on the cycle after leaving LOCKED.
- phase updates whenever prev updates.
- err_count:
  - Saturates at 2^ERR_W-1 and never wraps.
  - clr_err alone sets it to 0.
  - clr_err together with an error event sets it to 1 (clear applies first, then the increment).
- LOCK_COUNT=1: the first correct transition out of CHECK locks.

Decomposition:
- Shared package:
  - state enum {HUNT, CHECK, LOCKED}, 2-bit encoding;
  - constants SEQ0..SEQ3 = 3'd0, 3'd3, 3'd5, 3'd6;
  - a next-value function and a value-to-phase function.
- One natural sub-module, seq_lut: combinational legal/next/phase decode of a 3-bit value, instantiated twice (for q_in and for prev).
- The FSM, match counter and error counter stay in seq_monitor.

Test Plan:
- Reset then free-running 0,3,5,6,0,3 with valid=1 (LOCK_COUNT=4) -> locked rises the cycle after the 4th correct transition. err_count stays 0 and phase tracks 0,1,2,3,0.
- Once locked, inject 0,3,3 -> on the second 3: err_pulse=1 for one cycle, err_count=1, locked falls, state is CHECK. Continuing 5,6,0,3 relocks.
- Once locked, inject q_in=7 -> err_pulse=1 and illegal=1 on the same cycle, state is HUNT, err_count increments.
- valid toggling 1,0,1 with q_in garbage while valid=0 -> no state or phase change and no pulses. The sequence check resumes seamlessly.
- Force 2^ERR_W+3 errors -> err_count=255 (ERR_W=8). A clr_err coincident with an error gives 1; clr_err alone gives 0.
- reset=0 for one cycle while locked with err_count=5 -> all outputs 0 the next cycle and no err_pulse.

Source files
------------

// File: rtl/seq_monitor_pkg.sv
// seq_monitor_pkg: shared states, sequence constants and decode helpers for the counter monitor
package seq_monitor_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_e;
  localparam logic [2:0] SEQ0 = 3'd0;
  localparam logic [2:0] SEQ1 = 3'd3;
  localparam logic [2:0] SEQ2 = 3'd5;
  localparam logic [2:0] SEQ3 = 3'd6;
  function automatic logic [2:0] next_val(input logic [2:0] v);
    return v == SEQ0 ? SEQ1 : v == SEQ1 ? SEQ2 : v == SEQ2 ? SEQ3 : SEQ0;
  endfunction
  function automatic logic [1:0] to_phase(input logic [2:0] v);
    return v == SEQ1 ? 2'd1 : v == SEQ2 ? 2'd2 : v == SEQ3 ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/seq_lut.sv
// seq_lut: combinational legal/next/phase decode of one 3-bit counter value
module seq_lut
  import seq_monitor_pkg::*;
(
  input  logic [2:0] v_i,
  output logic       legal_o,
  output logic [2:0] next_o,
  output logic [1:0] phase_o
);
  assign legal_o = v_i inside {SEQ0, SEQ1, SEQ2, SEQ3};
  assign next_o  = next_val(v_i);
  assign phase_o = to_phase(v_i);
endmodule

// File: rtl/seq_monitor.sv
// seq_monitor: checks a counter against 0->3->5->6->0, locks after a clean run and counts errors
module seq_monitor
  import seq_monitor_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       q_in,
  input  logic             valid,
  input  logic             clr_err,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             err_pulse,
  output logic             illegal,
  output logic [ERR_W-1:0] err_count
);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  state_e state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [3:0] cnt_q, cnt_d;
  logic err_pulse_q, err_pulse_d, illegal_q, illegal_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic q_legal, p_legal, match, unused_q;
  logic [2:0] q_next, p_next;
  logic [1:0] q_phase;
  seq_lut u_q (.v_i(q_in), .legal_o(q_legal), .next_o(q_next), .phase_o(q_phase));
  seq_lut u_p (.v_i(prev_q), .legal_o(p_legal), .next_o(p_next), .phase_o(phase));
  assign unused_q = ^{q_next, q_phase};
  assign match = valid && p_legal && q_in == p_next;
  always_comb begin
    state_d = state_q;
    prev_d = prev_q;
    cnt_d = cnt_q;
    illegal_d = valid && !q_legal;
    err_pulse_d = valid && state_q == LOCKED && !match;
    if (valid) begin
      if (!q_legal) state_d = HUNT;
      else if (state_q == HUNT || !match) begin
        prev_d = q_in;
        cnt_d = '0;
        state_d = CHECK;
      end else begin
        prev_d = q_in;
        if (state_q == CHECK) begin
          cnt_d = cnt_q + 4'd1 == LC ? 4'd0 : cnt_q + 4'd1;
          state_d = cnt_q + 4'd1 == LC ? LOCKED : CHECK;
        end
      end
    end
    // clear lands before the increment so a coincident error leaves exactly one
    err_count_d = clr_err ? '0 : err_count_q;
    err_count_d = err_pulse_d && err_count_d != '1 ? err_count_d + ERR_W'(1) : err_count_d;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HUNT;
      prev_q <= '0;
      cnt_q <= '0;
      err_pulse_q <= 1'b0;
      illegal_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      cnt_q <= cnt_d;
      err_pulse_q <= err_pulse_d;
      illegal_q <= illegal_d;
      err_count_q <= err_count_d;
    end
  end
  assign locked = state_q == LOCKED;
  assign err_pulse = err_pulse_q;
  assign illegal = illegal_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_seq_monitor.sv
// tb_seq_monitor: directed vectors with hand-computed expectations for seq_monitor
module tb_seq_monitor;
  logic clk, reset, valid, clr_err, locked, err_pulse, illegal;
  logic [2:0] q_in;
  logic [1:0] phase;
  logic [7:0] err_count;
  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  int ec = 0;
  logic [2:0] seq [4];
  seq_monitor #(.LOCK_COUNT(4), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .valid(valid), .clr_err(clr_err),
    .locked(locked), .phase(phase), .err_pulse(err_pulse), .illegal(illegal), .err_count(err_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input int lk, input int ph, input int ep, input int il, input int cnt);
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(ep));
    chk({tag, ".illegal"}, 32'(illegal), 32'(il));
    chk({tag, ".err_count"}, 32'(err_count), 32'(cnt));
  endtask
  task automatic step(input logic [2:0] q, input logic v, input logic c);
    q_in = q;
    valid = v;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask
  task automatic err_relock(input logic c);
    step(seq[k], 1'b1, c);
    ec = c ? 1 : (ec < 255 ? ec + 1 : 255);
    chk("rep.err_pulse", 32'(err_pulse), 32'd1);
    chk("rep.err_count", 32'(err_count), 32'(ec));
    chk("rep.locked", 32'(locked), 32'd0);
    for (int j = 0; j < 4; j++) begin
      k = (k + 1) % 4;
      step(seq[k], 1'b1, 1'b0);
    end
    chk("relock.locked", 32'(locked), 32'd1);
    chk("relock.phase", 32'(phase), 32'(k));
  endtask
  initial begin
    seq[0] = 3'd0; seq[1] = 3'd3; seq[2] = 3'd5; seq[3] = 3'd6;
    reset = 1'b0; valid = 1'b0; clr_err = 1'b0; q_in = 3'd0;
    @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(3'd0, 1, 0); chk_out("run0", 0, 0, 0, 0, 0);
    step(3'd3, 1, 0); chk_out("run3", 0, 1, 0, 0, 0);
    step(3'd5, 1, 0); chk_out("run5", 0, 2, 0, 0, 0);
    step(3'd6, 1, 0); chk_out("run6", 0, 3, 0, 0, 0);
    step(3'd0, 1, 0); chk_out("lock0", 1, 0, 0, 0, 0);
    step(3'd3, 1, 0); chk_out("lock3", 1, 1, 0, 0, 0);
    step(3'd5, 1, 0); step(3'd6, 1, 0); step(3'd0, 1, 0);
    step(3'd3, 1, 0); chk_out("locked_run", 1, 1, 0, 0, 0);
    step(3'd3, 1, 0); chk_out("repeat", 0, 1, 1, 0, 1);
    step(3'd5, 1, 0); chk_out("after_err", 0, 2, 0, 0, 1);
    step(3'd6, 1, 0); step(3'd0, 1, 0); chk_out("check_run", 0, 0, 0, 0, 1);
    step(3'd3, 1, 0); chk_out("relock", 1, 1, 0, 0, 1);
    step(3'd7, 1, 0); chk_out("illegal_locked", 0, 1, 1, 1, 2);
    step(3'd0, 1, 0); chk_out("hunt0", 0, 0, 0, 0, 2);
    step(3'd3, 1, 0); step(3'd5, 1, 0);
    step(3'd6, 1, 0); chk_out("hunt_run", 0, 3, 0, 0, 2);
    step(3'd0, 1, 0); chk_out("hunt_lock", 1, 0, 0, 0, 2);
    step(3'd3, 1, 0); chk_out("v1", 1, 1, 0, 0, 2);
    step(3'd7, 0, 0); chk_out("v0a", 1, 1, 0, 0, 2);
    step(3'd2, 0, 0); chk_out("v0b", 1, 1, 0, 0, 2);
    step(3'd5, 1, 0); chk_out("resume", 1, 2, 0, 0, 2);
    k = 2;
    ec = 2;
    for (int i = 0; i < 257; i++) err_relock(1'b0);
    chk("saturated", 32'(err_count), 32'd255);
    err_relock(1'b1);
    chk("clr_with_err", 32'(err_count), 32'd1);
    k = (k + 1) % 4;
    step(seq[k], 1, 1);
    chk_out("clr_alone", 1, k, 0, 0, 0);
    ec = 0;
    for (int i = 0; i < 5; i++) err_relock(1'b0);
    chk_out("pre_reset", 1, k, 0, 0, 5);
    reset = 1'b0;
    step(seq[k], 1, 0);
    chk_out("mid_reset", 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(3'd4, 1, 0); chk_out("hunt_illegal", 0, 0, 0, 1, 0);
    step(3'd0, 1, 0); chk_out("hunt_accept", 0, 0, 0, 0, 0);
    step(3'd3, 1, 0); chk_out("check_again", 0, 1, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
